// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite compositor: the slot record,
// the transparent colour, the background pitch and the pipeline depth.
package sprite_pkg;

    localparam int SPR_DIM_W       = 7;
    localparam int SPR_ADDR_W      = 17;
    localparam int SPR_COLOR_W     = 12;
    localparam int BG_COLS_DEFAULT = 320;
    localparam int PIPE_LATENCY    = 3;

    localparam logic [SPR_COLOR_W-1:0] TRANSPARENT = '0;

    typedef struct packed {
        logic [9:0]            x;
        logic [9:0]            y;
        logic [SPR_DIM_W-1:0]  w;
        logic [SPR_DIM_W-1:0]  h;
        logic [SPR_ADDR_W-1:0] base;
        logic                  on;
    } slot_t;

    // Bounds are widened to 11 bits so a sprite hanging past column/row 1023 clips instead of wrapping.
    function automatic logic slot_hit(slot_t s, logic [9:0] hc, logic [9:0] vc);
        logic [10:0] x_end;
        logic [10:0] y_end;
        x_end = {1'b0, s.x} + 11'(s.w);
        y_end = {1'b0, s.y} + 11'(s.h);
        return s.on
            && ({1'b0, hc} >= {1'b0, s.x}) && ({1'b0, hc} < x_end)
            && ({1'b0, vc} >= {1'b0, s.y}) && ({1'b0, vc} < y_end);
    endfunction

    // Only meaningful when slot_hit is true, so the offsets are never negative.
    function automatic logic [SPR_ADDR_W-1:0] sheet_addr(slot_t s, logic [9:0] hc, logic [9:0] vc);
        logic [9:0] dx;
        logic [9:0] dy;
        dx = hc - s.x;
        dy = vc - s.y;
        return s.base + SPR_ADDR_W'(dx) + SPR_ADDR_W'(s.w) * SPR_ADDR_W'(dy);
    endfunction

endpackage

// File: rtl/sprite_slot_bank.sv
// Double-buffered sprite slot registers: writes land in the shadow bank and
// the whole shadow bank becomes active on frame_sync.
module sprite_slot_bank
    import sprite_pkg::*;
#(
    parameter int NUM_SLOTS = 16,
    parameter int SLOT_W    = 4
) (
    input  logic                        clk_25m,
    input  logic                        rst,
    input  logic                        frame_sync,
    input  logic                        wr_en,
    input  logic [SLOT_W-1:0]           wr_slot,
    input  slot_t                       wr_rec,
    output slot_t [NUM_SLOTS-1:0]       active
);

    slot_t [NUM_SLOTS-1:0] shadow;
    logic                  wr_ok;

    assign wr_ok = wr_en && (int'(wr_slot) < NUM_SLOTS);

    // NOTE: the banks take the async reset even though they are register files; a reset mid-frame must disable every sprite at once.
    always_ff @(posedge clk_25m or posedge rst) begin
        if (rst) begin
            shadow <= '0;
            active <= '0;
        end else begin
            // NOTE: non-blocking assignments here so the swap reads the shadow value from before this edge's write.
            if (wr_ok)
                shadow[wr_slot] <= wr_rec;
            if (frame_sync) begin
                for (int i = 0; i < NUM_SLOTS; i++)
                    active[i] <= (wr_ok && int'(wr_slot) == i) ? wr_rec : shadow[i];
            end
        end
    end

endmodule

// File: rtl/sprite_compositor.sv
// Three-stage sprite-over-background pixel pipeline: hit test and ROM
// addressing, ROM read, then transparency select onto 4:4:4 RGB.
module sprite_compositor
    import sprite_pkg::*;
#(
    parameter int NUM_SLOTS = 16,
    parameter int SLOT_W    = 4,
    parameter int DIM_W     = SPR_DIM_W,
    parameter int ADDR_W    = SPR_ADDR_W,
    parameter int COLOR_W   = SPR_COLOR_W,
    parameter int BG_COLS   = BG_COLS_DEFAULT
) (
    input  logic               clk_25m,
    input  logic               rst,
    input  logic               valid,
    input  logic [9:0]         hc,
    input  logic [9:0]         vc,
    input  logic               frame_sync,
    input  logic               wr_en,
    input  logic [SLOT_W-1:0]  wr_slot,
    input  logic [9:0]         wr_x,
    input  logic [9:0]         wr_y,
    input  logic [DIM_W-1:0]   wr_w,
    input  logic [DIM_W-1:0]   wr_h,
    input  logic [ADDR_W-1:0]  wr_base,
    input  logic               wr_on,
    output logic [ADDR_W-1:0]  spr_addr,
    input  logic [COLOR_W-1:0] spr_data,
    output logic [ADDR_W-1:0]  bg_addr,
    input  logic [COLOR_W-1:0] bg_data,
    output logic [3:0]         vgaRed,
    output logic [3:0]         vgaGreen,
    output logic [3:0]         vgaBlue,
    output logic               pix_hit,
    output logic [SLOT_W-1:0]  pix_slot
);

    slot_t                 wr_rec;
    slot_t [NUM_SLOTS-1:0] active;

    logic                  hit_c;
    logic [SLOT_W-1:0]     slot_c;
    logic [ADDR_W-1:0]     spr_addr_c;
    logic [ADDR_W-1:0]     bg_addr_c;

    logic                  hit1, hit2;
    logic [SLOT_W-1:0]     slot1, slot2;
    logic                  valid1, valid2;
    logic [COLOR_W-1:0]    rgb;

    assign wr_rec = '{x: wr_x, y: wr_y, w: wr_w, h: wr_h, base: wr_base, on: wr_on};

    sprite_slot_bank #(
        .NUM_SLOTS (NUM_SLOTS),
        .SLOT_W    (SLOT_W)
    ) u_bank (
        .clk_25m    (clk_25m),
        .rst        (rst),
        .frame_sync (frame_sync),
        .wr_en      (wr_en),
        .wr_slot    (wr_slot),
        .wr_rec     (wr_rec),
        .active     (active)
    );

    // Scan from the lowest priority upward so the lowest-index hit overwrites the rest.
    always_comb begin
        // NOTE: every output gets a default first, so no path through the loop can infer a latch.
        hit_c      = 1'b0;
        slot_c     = '0;
        spr_addr_c = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (slot_hit(active[i], hc, vc)) begin
                hit_c      = 1'b1;
                slot_c     = SLOT_W'(i);
                spr_addr_c = sheet_addr(active[i], hc, vc);
            end
        end
    end

    assign bg_addr_c = ADDR_W'(hc >> 1) + ADDR_W'(BG_COLS) * ADDR_W'(vc >> 1);

    always_ff @(posedge clk_25m or posedge rst) begin
        if (rst) begin
            spr_addr <= '0;
            bg_addr  <= '0;
            hit1     <= 1'b0;
            slot1    <= '0;
            valid1   <= 1'b0;
            hit2     <= 1'b0;
            slot2    <= '0;
            valid2   <= 1'b0;
            rgb      <= '0;
            pix_hit  <= 1'b0;
            pix_slot <= '0;
        end else begin
            spr_addr <= spr_addr_c;
            bg_addr  <= bg_addr_c;
            hit1     <= hit_c;
            slot1    <= slot_c;
            valid1   <= valid;
            hit2     <= hit1;
            slot2    <= slot1;
            valid2   <= valid1;
            // A transparent winner shows the background; lower-priority slots never fall through.
            if (!valid2) begin
                rgb      <= '0;
                pix_hit  <= 1'b0;
                pix_slot <= '0;
            end else if (hit2 && spr_data != TRANSPARENT) begin
                rgb      <= spr_data;
                pix_hit  <= 1'b1;
                pix_slot <= slot2;
            end else begin
                rgb      <= bg_data;
                pix_hit  <= 1'b0;
                pix_slot <= '0;
            end
        end
    end

    assign vgaRed   = rgb[11:8];
    assign vgaGreen = rgb[7:4];
    assign vgaBlue  = rgb[3:0];

endmodule

// File: doc/sprite_compositor.md
Name: sprite_compositor

Overview:
- Parametrised successor to the fixed-object VGA pixel selector.
- Composites up to NUM_SLOTS generic sprites over a 2x-upscaled background; each slot has its own position, size, sheet base address and enable, loaded through a register-write port.
- Slot updates are double-buffered: the active set swaps only on frame_sync, so no sprite tears mid-frame.
- Drives one shared sprite-sheet ROM and one background ROM, both with 1-cycle read latency, and outputs 4:4:4 RGB to the VGA pins.

Parameters:
- NUM_SLOTS, 16, number of sprite slots; lowest index has highest priority.
- SLOT_W, 4, slot index width; must satisfy 2^SLOT_W >= NUM_SLOTS.
- DIM_W, 7, width of the per-slot sprite width/height fields (max 127).
- ADDR_W, 17, sprite ROM and background ROM address width.
- COLOR_W, 12, pixel colour width; the value 0 is transparent.
- BG_COLS, 320, background ROM row pitch, in half-resolution pixels.

Ports:
- clk_25m, input, 1, pixel clock.
- rst, input, 1, asynchronous reset, active-high.
- valid, input, 1, display-active flag aligned with hc/vc.
- hc, input, 10, current pixel column.
- vc, input, 10, current pixel row.
- frame_sync, input, 1, one-cycle pulse that copies the shadow bank to the active bank.
- wr_en, input, 1, shadow-bank write strobe.
- wr_slot, input, SLOT_W, slot to write.
- wr_x, input, 10, sprite left column.
- wr_y, input, 10, sprite top row.
- wr_w, input, DIM_W, sprite width.
- wr_h, input, DIM_W, sprite height.
- wr_base, input, ADDR_W, sheet address of the sprite's top-left pixel.
- wr_on, input, 1, slot enable.
- spr_addr, output, ADDR_W, sprite ROM address.
- spr_data, input, COLOR_W, sprite ROM data, returned 1 cycle after spr_addr.
- bg_addr, output, ADDR_W, background ROM address.
- bg_data, input, COLOR_W, background ROM data, returned 1 cycle after bg_addr.
- vgaRed, output, 4, red channel.
- vgaGreen, output, 4, green channel.
- vgaBlue, output, 4, blue channel.
- pix_hit, output, 1, debug: output pixel came from a sprite.
- pix_slot, output, SLOT_W, debug: winning slot, aligned with RGB.

Behaviour:
- Reset (async, any time, including mid-frame): both banks cleared (all slots disabled, fields 0). spr_addr, bg_addr, RGB, pix_hit and pix_slot all 0; pipeline valid bits 0.
- Write: when wr_en=1 and wr_slot < NUM_SLOTS, the shadow slot is written at the clock edge. wr_slot >= NUM_SLOTS is ignored.
- Swap: on frame_sync=1, active <= shadow for every slot. If wr_en and frame_sync occur in the same cycle, the written value is forwarded into the active bank.
- Hit test, stage 1:
  - Slot i hits when it is enabled, x <= hc < x+w, and y <= vc < y+h.
  - Compares use 11-bit sums, so sprites extending past 1023 clip and never wrap.
  - w=0 or h=0 never hits.
- Priority: the lowest-index hit wins. Only that slot's pixel is fetched; if it is transparent, the background shows (no fall-through to lower-priority slots).
- Address arithmetic:
  - spr_addr = wr_base + (hc-x) + w*(vc-y), truncated to ADDR_W.
  - bg_addr = (hc>>1) + BG_COLS*(vc>>1), truncated to ADDR_W.
- Stage 1 (registered at cycle N+1): spr_addr, bg_addr, hit, slot, valid.
- Stage 2 (cycle N+2): ROM data arrives; hit, slot and valid are delayed one cycle to stay aligned.
- Stage 3 (registered at cycle N+3):
  - If valid=0: RGB 0, pix_hit 0.
  - Else if hit and spr_data != 0: RGB = spr_data, pix_hit 1, pix_slot = slot.
  - Else: RGB = bg_data, pix_hit 0.
- Latency: fixed 3 cycles from hc/vc/valid to RGB.
- Throughput: one pixel per cycle, no stalls.
- With no slot hitting, spr_addr holds 0.

Decomposition:
- Shared package sprite_pkg holds:
  - the slot record type (x, y, w, h, base, on);
  - the transparent-colour constant;
  - the BG_COLS default;
  - the pipeline-latency constant (3).
- Natural sub-module: sprite_slot_bank. It holds the shadow and active banks, the write port and the frame_sync swap, and exports the active records. The hit/priority/address pipeline stays in sprite_compositor.

Test Plan:
- Reset mid-frame: write slot 0 (x=100, y=50, w=16, h=16, on), pulse frame_sync, assert rst at hc=105, vc=55 -> RGB 0, spr_addr 0 immediately; after release, slot 0 does not hit.
- Single sprite: slot 2 at (100,50), w=16, h=16, base=0x200, swapped in; hc=103, vc=52 -> spr_addr=0x200+3+32=0x223 one cycle later; with ROM word 0xF00, RGB=F/0/0 and pix_slot=2 three cycles after.
- Priority plus transparency: slots 1 and 3 overlap at (200,100); slot 1's pixel is 0 -> RGB equals bg_data at bg_addr=100+320*50=16100 and pix_hit=0; slot 3 is not shown.
- Double buffer: rewrite slot 0 with x=300 mid-frame -> output still shows it at x=100 until frame_sync; a write in the same cycle as frame_sync is active on the next cycle.
- Edge clipping: slot at x=1020, w=16; hc=1023 hits; hc=3 does not hit (no wrap). A slot with w=0 never hits.
- Blanking: valid=0 while inside a sprite -> RGB 0, pix_hit 0, exactly 3 cycles later.
